// File: rtl/lpif_unpack_pkg.sv
// rtl/lpif_unpack_pkg.sv - shared lane/word types and lane-scan helpers for the LPIF downstream unpacker
//
// Purpose : LANES constant, per-lane record lane_t, four-lane word_t, and the
//           helpers that locate the next valid lane inside a stored word.
// Ports   : none (package).
// Config  : LPIF_UNPACK_CRC_EN adds crc/crc_valid to lane_t.
package lpif_unpack_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 128;

  typedef struct packed {
    logic [LANE_W-1:0] data;
    logic [3:0]        state;
    logic [1:0]        protid;
    logic              dvalid;
    logic              valid;
`ifdef LPIF_UNPACK_CRC_EN
    logic [7:0]        crc;
    logic              crc_valid;
`endif
  } lane_t;

  typedef lane_t [LANES-1:0] word_t;

  typedef logic [1:0] lane_idx_t;

  // Lowest valid lane at or above 'from'. Callers only ask while such a lane
  // exists, so the zero fallback is never observed.
  function automatic lane_idx_t first_valid_lane(input logic [LANES-1:0] valid,
                                                 input lane_idx_t        from);
    lane_idx_t sel;
    sel = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (valid[k] && (k >= int'(from))) sel = lane_idx_t'(k);
    end
    return sel;
  endfunction

  // True when some valid lane sits strictly above 'lane'.
  function automatic logic more_lanes_after(input logic [LANES-1:0] valid,
                                            input lane_idx_t        lane);
    logic more;
    more = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (valid[k] && (k > int'(lane))) more = 1'b1;
    end
    return more;
  endfunction

endpackage

// File: rtl/lpif_dstrm_quarter_unpack_if.sv
// rtl/lpif_dstrm_quarter_unpack_if.sv - LPIF downstream quarter-rate input and single-lane flit output bundle
//
// Purpose : groups the 4-lane LPIF downstream fields and the 1-lane flit stream.
// Signals : dstrm_state[15:0] dstrm_protid[7:0] dstrm_data[511:0] dstrm_dvalid[3:0]
//           dstrm_crc[31:0] dstrm_crc_valid[3:0] dstrm_valid[3:0]   (producer -> unpacker)
//           flit_data[127:0] flit_state[3:0] flit_protid[1:0] flit_dvalid
//           flit_crc[7:0] flit_crc_valid flit_valid                    (unpacker -> consumer)
//           flit_ready                                                 (consumer -> unpacker)
// Modports: master = environment side, slave = unpacker side.
interface lpif_dstrm_quarter_unpack_if;

  logic [15:0]  dstrm_state;
  logic [7:0]   dstrm_protid;
  logic [511:0] dstrm_data;
  logic [3:0]   dstrm_dvalid;
  logic [31:0]  dstrm_crc;
  logic [3:0]   dstrm_crc_valid;
  logic [3:0]   dstrm_valid;

  logic [127:0] flit_data;
  logic [3:0]   flit_state;
  logic [1:0]   flit_protid;
  logic         flit_dvalid;
  logic [7:0]   flit_crc;
  logic         flit_crc_valid;
  logic         flit_valid;
  logic         flit_ready;

  modport master (
    output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
           dstrm_crc, dstrm_crc_valid, dstrm_valid, flit_ready,
    input  flit_data, flit_state, flit_protid, flit_dvalid,
           flit_crc, flit_crc_valid, flit_valid
  );

  modport slave (
    input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
           dstrm_crc, dstrm_crc_valid, dstrm_valid, flit_ready,
    output flit_data, flit_state, flit_protid, flit_dvalid,
           flit_crc, flit_crc_valid, flit_valid
  );

endinterface

// File: rtl/lpif_unpack_fifo.sv
// rtl/lpif_unpack_fifo.sv - word_t FIFO with flush, exact level and push-while-full-on-pop
//
// Purpose : buffers DEPTH four-lane words; the head word is read combinationally.
// Ports   : clk, rst_n (async, active-low), flush (sync empty),
//           push/push_data, pop, pop_data (head word), full, empty, level.
module lpif_unpack_fifo
  import lpif_unpack_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  word_t         push_data,
  input  logic          pop,
  output word_t         pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  word_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr.
  assign do_push  = push && (!full || pop) && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lpif_dstrm_quarter_unpack.sv
// rtl/lpif_dstrm_quarter_unpack.sv - unpacks 4-lane LPIF downstream words into a 1-lane flit stream
//
// Purpose : buffers quarter-rate words and emits their valid lanes in
//           ascending order, one per flit_valid && flit_ready, skipping
//           invalid lanes without bubbles.
// Ports   : clk_wr, rst_wr_n (async, active-low), rx_online (low flushes),
//           clear_status (clears overflow), overflow (sticky drop flag),
//           fifo_level (words held), bus (slave side of the flit bundle).
// Config  : LPIF_UNPACK_CRC_EN stores and forwards per-lane CRC; otherwise
//           flit_crc/flit_crc_valid are tied to zero.
module lpif_dstrm_quarter_unpack
  import lpif_unpack_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr_n,
  input  logic                          rx_online,
  input  logic                          clear_status,
  output logic                          overflow,
  output logic [LVL_W-1:0]              fifo_level,
  lpif_dstrm_quarter_unpack_if.slave    bus
);

  word_t            in_word;
  word_t            head_word;
  lane_t            cur;
  logic [LANES-1:0] head_valid;
  lane_idx_t        lane_ptr;
  lane_idx_t        cur_lane;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_req;
  logic             accept;
  logic             last_lane;
  logic             pop;
  logic             drop;

  always_comb begin
    in_word = '0;
    for (int k = 0; k < LANES; k++) begin
      in_word[k].data      = bus.dstrm_data[LANE_W*k +: LANE_W];
      in_word[k].state     = bus.dstrm_state[4*k +: 4];
      in_word[k].protid    = bus.dstrm_protid[2*k +: 2];
      in_word[k].dvalid    = bus.dstrm_dvalid[k];
      in_word[k].valid     = bus.dstrm_valid[k];
`ifdef LPIF_UNPACK_CRC_EN
      in_word[k].crc       = bus.dstrm_crc[8*k +: 8];
      in_word[k].crc_valid = bus.dstrm_crc_valid[k];
`endif
    end
  end

`ifndef LPIF_UNPACK_CRC_EN
  logic unused_crc;
  assign unused_crc = ^{bus.dstrm_crc, bus.dstrm_crc_valid};
`endif

  always_comb begin
    head_valid = '0;
    for (int k = 0; k < LANES; k++) head_valid[k] = head_word[k].valid;
  end

  // lane_ptr only records where the scan resumes; the emitted lane is the
  // first valid one at or above it, so holes cost no cycles.
  assign cur_lane  = first_valid_lane(head_valid, lane_ptr);
  assign cur       = head_word[cur_lane];
  assign last_lane = !more_lanes_after(head_valid, cur_lane);
  assign accept    = !fifo_empty && bus.flit_ready;
  assign pop       = accept && last_lane && rx_online;
  assign push_req  = rx_online && (|bus.dstrm_valid);
  assign drop      = push_req && fifo_full && !pop;

  lpif_unpack_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_wr),
    .rst_n     (rst_wr_n),
    .flush     (!rx_online),
    .push      (push_req),
    .push_data (in_word),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Stored words may hold stale or unknown data once popped, so every flit
  // field is forced to zero while nothing is buffered.
  always_comb begin
    bus.flit_valid     = !fifo_empty;
    bus.flit_data      = '0;
    bus.flit_state     = '0;
    bus.flit_protid    = '0;
    bus.flit_dvalid    = 1'b0;
    bus.flit_crc       = 8'h0;
    bus.flit_crc_valid = 1'b0;
    if (!fifo_empty) begin
      bus.flit_data      = cur.data;
      bus.flit_state     = cur.state;
      bus.flit_protid    = cur.protid;
      bus.flit_dvalid    = cur.dvalid;
`ifdef LPIF_UNPACK_CRC_EN
      bus.flit_crc       = cur.crc;
      bus.flit_crc_valid = cur.crc_valid;
`endif
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      lane_ptr <= '0;
    end else if (!rx_online) begin
      lane_ptr <= '0;
    end else if (accept) begin
      lane_ptr <= last_lane ? lane_idx_t'(0) : lane_idx_t'(cur_lane + 2'd1);
    end
  end

  // A drop in the same cycle as clear_status leaves overflow set.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_status) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/lpif_dstrm_quarter_unpack.md
LPIF_DSTRM_QUARTER_UNPACK -- requirements
Module: lpif_dstrm_quarter_unpack

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 4-lane quarter-rate words buffered; power of 2, minimum 2.
REQ-002 clk_wr  input  1  sole clock; all logic on its rising edge.
REQ-003 rst_wr_n  input  1  reset, asynchronous and active-low.
REQ-004 rx_online  input  1  link online qualifier (delayed online from auto-sync); low flushes the block.
REQ-005 dstrm_state / dstrm_protid / dstrm_data  input  16 / 8 / 512  LPIF downstream fields; lane k uses [4k+:4] / [2k+:2] / [128k+:128].
REQ-006 dstrm_dvalid / dstrm_crc / dstrm_crc_valid / dstrm_valid  input  4 / 32 / 4 / 4  per-lane flags; CRC lane k uses [8k+:8].
REQ-007 flit_data / flit_state / flit_protid / flit_dvalid  output  128 / 4 / 2 / 1  single-lane flit fields.
REQ-008 flit_crc / flit_crc_valid  output  8 / 1  single-lane CRC fields.
REQ-009 flit_valid  output  1  flit fields hold a valid flit.
REQ-010 flit_ready  input  1  consumer accepts the flit when flit_valid && flit_ready.
REQ-011 clear_status  input  1  synchronous clear of overflow.
REQ-012 overflow  output  1  sticky: a word was dropped.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH+1)  occupied word slots.

Function
REQ-014 Push a word when rx_online && |dstrm_valid; store every lane's fields, including dstrm_valid.
REQ-015 Never push a word with dstrm_valid == 4'b0000.
REQ-016 Emit the stored lanes with valid[k]=1 in ascending k order, one per accepted handshake.
REQ-017 Skip lanes with valid[k]=0 with zero bubble cycles.
REQ-018 Latency: a word pushed at edge N drives flit_valid=1 during cycle N+1 (FIFO and output empty beforehand).
REQ-019 Flit outputs come from the head word and the lane pointer; flit_valid=1 whenever the FIFO is non-empty.
REQ-020 flit_valid and the flit fields stay stable while flit_valid && !flit_ready.
REQ-021 Pop the head word, and reset the lane pointer, on acceptance of the last valid lane.
REQ-022 Push when full without a same-cycle pop: drop the incoming word and set overflow; stored contents are unchanged.
REQ-023 Push when full with a same-cycle pop: accept the word; overflow is not set.
REQ-024 Push when empty: accept the word; a same-cycle pop is impossible.
REQ-025 Pointers wrap modulo FIFO_DEPTH; fifo_level is exact, 0..FIFO_DEPTH.
REQ-026 rx_online low at edge N: empty the FIFO and zero the lane pointer at edge N, so flit_valid=0 in cycle N+1; overflow is kept.
REQ-027 clear_status at edge N: overflow=0 in cycle N+1.
REQ-028 If clear_status and a new overflow event coincide, overflow is 1 (set wins).

Reset
REQ-029 Asynchronous assertion: flit_valid=0, overflow=0, fifo_level=0, pointers=0, all flit fields=0.
REQ-030 Reset mid-transfer discards all buffered words; no flit is emitted until the next push.
REQ-031 Storage arrays need no reset; outputs are masked to 0 while empty.

Configuration
REQ-032 Macro LPIF_UNPACK_CRC_EN defined: store crc/crc_valid per lane and drive flit_crc and flit_crc_valid from them.
REQ-033 Macro LPIF_UNPACK_CRC_EN undefined: no CRC storage; flit_crc=8'h0 and flit_crc_valid=0 constantly.

Structure
REQ-034 Package lpif_unpack_pkg holds the LANES=4 constant, the per-lane packed struct lane_t (data, state, protid, dvalid, valid, optional crc and crc_valid) and the word_t = lane_t[3:0] typedef.
REQ-035 Sub-module lpif_unpack_fifo, a generic word_t FIFO with push, pop, full, empty and level; the lane pointer and overflow logic stay in the top.

Verification
REQ-036 Single word, dstrm_valid=4'hF, flit_ready=1 -> 4 flits on 4 consecutive cycles, lane 0 first, flit_data = dstrm_data[127:0] through [511:384].
REQ-037 Sparse word, dstrm_valid=4'b1010, flit_ready=1 -> exactly 2 flits (lane 1 then lane 3) with no bubble; fifo_level returns to 0.
REQ-038 Back-to-back pushes with flit_ready=0, FIFO_DEPTH=4 -> fifo_level=4, the 5th push sets overflow=1, the first 4 words are emitted intact afterwards.
REQ-039 Full FIFO, last lane of the head word accepted in the same cycle as a push -> no overflow, fifo_level stays 4.
REQ-040 rx_online dropped mid-word -> flit_valid=0 next cycle, fifo_level=0, overflow unchanged; clear_status then gives overflow=0.
REQ-041 Build without LPIF_UNPACK_CRC_EN, dstrm_crc=32'hDEADBEEF -> flit_crc=0 and flit_crc_valid=0 on every flit.
